// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared definitions for the mouse cursor tracker: widths, default extents,
// FSM state encoding, packet record and sign/zero-extension helpers.
package mouse_cursor_tracker_pkg;

    localparam int unsigned DELTA_W = 9;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = 12;

    localparam int unsigned X_MAX_DEFAULT = 639;
    localparam int unsigned Y_MAX_DEFAULT = 479;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SUM    = 2'd1;
    localparam logic [1:0] ST_CLAMP  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    typedef struct packed {
        logic [DELTA_W-1:0] dx;
        logic [DELTA_W-1:0] dy;
        logic [2:0]         btn;
    } packet_t;

    function automatic logic signed [SUM_W-1:0] sext_delta(input logic [DELTA_W-1:0] d);
        return {{(SUM_W-DELTA_W){d[DELTA_W-1]}}, d};
    endfunction

    function automatic logic signed [SUM_W-1:0] zext_coord(input logic [COORD_W-1:0] c);
        return {{(SUM_W-COORD_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/mouse_cursor_tracker_clamp.sv
// cursor_clamp: combinational saturation of one signed cursor axis into
// the range 0..MAX.
module cursor_clamp
    import mouse_cursor_tracker_pkg::*;
#(
    parameter int unsigned MAX = X_MAX_DEFAULT
) (
    input  logic signed [SUM_W-1:0]   value,
    output logic        [COORD_W-1:0] result
);

    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);
    localparam logic [COORD_W-1:0]      MAX_C = COORD_W'(MAX);

    always_comb begin
        if (value[SUM_W-1]) begin
            result = '0;
        end else if (value > MAX_S) begin
            result = MAX_C;
        end else begin
            result = value[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Mouse cursor tracker: accumulates mouse packet deltas into a clamped screen
// position. Define CURSOR_FRAME_SYNC_EN to defer commits to frame_start.
module mouse_cursor_tracker
    import mouse_cursor_tracker_pkg::*;
#(
    parameter int unsigned X_MAX  = X_MAX_DEFAULT,
    parameter int unsigned Y_MAX  = Y_MAX_DEFAULT,
    parameter int unsigned X_INIT = 320,
    parameter int unsigned Y_INIT = 240
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DELTA_W-1:0] xm,
    input  logic [DELTA_W-1:0] ym,
    input  logic [2:0]         btnm,
    input  logic               m_done_tick,
    input  logic               frame_start,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic [2:0]         btn,
    output logic               pos_tick,
    output logic               click_tick,
    output logic               overrun
);

    logic [1:0]               state;
    packet_t                  in_pkt;
    packet_t                  cap;
    packet_t                  pend;
    logic                     pend_valid;
    logic                     loaded;
    logic signed [SUM_W-1:0]  sum_x;
    logic signed [SUM_W-1:0]  sum_y;
    logic [COORD_W-1:0]       clamp_x;
    logic [COORD_W-1:0]       clamp_y;

    logic clamp_fire;
    logic wait_fire;
    logic load_now;
    logic commit_exit;
    logic busy_tick;
    logic direct_take;
    logic pend_write;
    logic pend_clear;
    logic drop;

`ifdef CURSOR_FRAME_SYNC_EN
    assign clamp_fire = frame_start;
    assign wait_fire  = frame_start;
`else
    logic unused_frame_start;
    assign clamp_fire         = 1'b1;
    assign wait_fire          = 1'b0;
    assign unused_frame_start = frame_start;
`endif

    assign in_pkt = {xm, ym, btnm};

    cursor_clamp #(.MAX(X_MAX)) u_clamp_x (
        .value  (sum_x),
        .result (clamp_x)
    );

    cursor_clamp #(.MAX(Y_MAX)) u_clamp_y (
        .value  (sum_y),
        .result (clamp_y)
    );

    // Outputs load at the edge leaving CLAMP (or on the awaited frame_start),
    // so the COMMIT cycle already shows the new position with pos_tick high.
    always_comb begin
        load_now    = ((state == ST_CLAMP) && clamp_fire) ||
                      ((state == ST_COMMIT) && !loaded && wait_fire);
        commit_exit = (state == ST_COMMIT) && (loaded || wait_fire);
        busy_tick   = m_done_tick && (state != ST_IDLE);
        direct_take = commit_exit && m_done_tick && !pend_valid;
        pend_write  = busy_tick && !direct_take && (!pend_valid || commit_exit);
        pend_clear  = commit_exit && pend_valid && !m_done_tick;
        drop        = busy_tick && pend_valid && !commit_exit;
    end

    // A slot freed by COMMIT exit may be refilled in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            cap        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            loaded     <= 1'b0;
            sum_x      <= '0;
            sum_y      <= '0;
            overrun    <= 1'b0;
        end else begin
            if (pend_write) begin
                pend       <= in_pkt;
                pend_valid <= 1'b1;
            end else if (pend_clear) begin
                pend_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (m_done_tick) begin
                        cap   <= in_pkt;
                        state <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    sum_x <= zext_coord(cur_x) + sext_delta(cap.dx);
                    sum_y <= zext_coord(cur_y) - sext_delta(cap.dy);
                    state <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    loaded <= clamp_fire;
                    state  <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (commit_exit) begin
                        if (pend_valid) begin
                            cap   <= pend;
                            state <= ST_SUM;
                        end else if (m_done_tick) begin
                            cap   <= in_pkt;
                            state <= ST_SUM;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_x      <= COORD_W'(X_INIT);
            cur_y      <= COORD_W'(Y_INIT);
            btn        <= '0;
            pos_tick   <= 1'b0;
            click_tick <= 1'b0;
        end else begin
            pos_tick   <= load_now;
            click_tick <= load_now && cap.btn[0] && !btn[0];
            if (load_now) begin
                cur_x <= clamp_x;
                cur_y <= clamp_y;
                btn   <= cap.btn;
            end
        end
    end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench for mouse_cursor_tracker: directed scenarios plus a
// randomized run against a packet/timing-level reference model.
module tb_mouse_cursor_tracker;

    localparam int X_MAX  = 639;
    localparam int Y_MAX  = 479;
    localparam int X_INIT = 320;
    localparam int Y_INIT = 240;
`ifdef CURSOR_FRAME_SYNC_EN
    localparam bit SYNC_BUILD = 1'b1;
`else
    localparam bit SYNC_BUILD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [8:0] xm = '0;
    logic [8:0] ym = '0;
    logic [2:0] btnm = '0;
    logic       m_done_tick = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic [2:0] btn;
    logic       pos_tick;
    logic       click_tick;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        int         x;
        int         y;
        logic [2:0] b;
        logic       click;
    } exp_t;

    mouse_cursor_tracker #(
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX),
        .X_INIT (X_INIT),
        .Y_INIT (Y_INIT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .xm          (xm),
        .ym          (ym),
        .btnm        (btnm),
        .m_done_tick (m_done_tick),
        .frame_start (frame_start),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .btn         (btn),
        .pos_tick    (pos_tick),
        .click_tick  (click_tick),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    function automatic int clampi(input int v, input int max);
        if (v < 0) return 0;
        if (v > max) return max;
        return v;
    endfunction

    task automatic idle_inputs();
        m_done_tick = 1'b0;
        xm          = '0;
        ym          = '0;
        btnm        = '0;
        frame_start = SYNC_BUILD;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_packet(input int dx, input int dy, input logic [2:0] b,
                               output int lat, output logic [9:0] ox,
                               output logic [9:0] oy, output logic [2:0] ob,
                               output logic oc);
        xm = 9'(dx);
        ym = 9'(dy);
        btnm = b;
        m_done_tick = 1'b1;
        @(posedge CLK);
        #1;
        m_done_tick = 1'b0;
        lat = -1;
        ox = '0;
        oy = '0;
        ob = '0;
        oc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (pos_tick) begin
                lat = k;
                ox = cur_x;
                oy = cur_y;
                ob = btn;
                oc = click_tick;
                break;
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_vec++; if (cur_x !== 10'(X_INIT)) begin n_err++; $display("FAIL reset_cur_x: got %0d expected %0d", cur_x, X_INIT); end
        n_vec++; if (cur_y !== 10'(Y_INIT)) begin n_err++; $display("FAIL reset_cur_y: got %0d expected %0d", cur_y, Y_INIT); end
        n_vec++; if (btn !== 3'b000) begin n_err++; $display("FAIL reset_btn: got %b expected 000", btn); end
        n_vec++; if (pos_tick !== 1'b0) begin n_err++; $display("FAIL reset_pos_tick: got %b expected 0", pos_tick); end
        n_vec++; if (click_tick !== 1'b0) begin n_err++; $display("FAIL reset_click_tick: got %b expected 0", click_tick); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic();
        int lat; logic [9:0] ox, oy; logic [2:0] ob; logic oc;
        do_reset();
        send_packet(5, 3, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        n_vec++; if (ox !== 10'd325) begin n_err++; $display("FAIL basic_x: got %0d expected 325", ox); end
        n_vec++; if (oy !== 10'd237) begin n_err++; $display("FAIL basic_y: got %0d expected 237", oy); end
        n_vec++; if (oc !== 1'b0) begin n_err++; $display("FAIL basic_click: got %b expected 0", oc); end
    endtask

    task automatic test_clamp_high();
        int lat; logic [9:0] ox, oy; logic [2:0] ob; logic oc;
        do_reset();
        send_packet(255, 235, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (ox !== 10'd575 || oy !== 10'd5) begin n_err++; $display("FAIL clamp_hi_step1: got (%0d,%0d) expected (575,5)", ox, oy); end
        send_packet(55, 0, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (ox !== 10'd630 || oy !== 10'd5) begin n_err++; $display("FAIL clamp_hi_step2: got (%0d,%0d) expected (630,5)", ox, oy); end
        send_packet(20, 10, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL clamp_hi_latency: got %0d expected 3", lat); end
        n_vec++; if (ox !== 10'd639) begin n_err++; $display("FAIL clamp_hi_x: got %0d expected 639", ox); end
        n_vec++; if (oy !== 10'd0) begin n_err++; $display("FAIL clamp_hi_y: got %0d expected 0", oy); end
    endtask

    task automatic test_clamp_low();
        int lat; logic [9:0] ox, oy; logic [2:0] ob; logic oc;
        do_reset();
        send_packet(-256, -230, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (ox !== 10'd64 || oy !== 10'd470) begin n_err++; $display("FAIL clamp_lo_step1: got (%0d,%0d) expected (64,470)", ox, oy); end
        send_packet(-62, 0, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (ox !== 10'd2 || oy !== 10'd470) begin n_err++; $display("FAIL clamp_lo_step2: got (%0d,%0d) expected (2,470)", ox, oy); end
        send_packet(-256, -100, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (ox !== 10'd0) begin n_err++; $display("FAIL clamp_lo_x: got %0d expected 0", ox); end
        n_vec++; if (oy !== 10'd479) begin n_err++; $display("FAIL clamp_lo_y: got %0d expected 479", oy); end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int clicks[$];
        int lat; logic [9:0] ox, oy; logic [2:0] ob; logic oc;
        logic [9:0] x1 = '0;
        logic [9:0] y1 = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            xm = 9'(1 << i);
            ym = 9'(1 << i);
            btnm = (i < 2) ? 3'b001 : 3'b000;
            m_done_tick = 1'b1;
            @(posedge CLK);
            #1;
        end
        idle_inputs();
        for (int cyc = 3; cyc <= 12; cyc++) begin
            @(negedge CLK);
            if (pos_tick) pulses.push_back(cyc);
            if (click_tick) clicks.push_back(cyc);
            if (cyc == 3) begin x1 = cur_x; y1 = cur_y; end
            @(posedge CLK);
            #1;
        end
        n_vec++; if (pulses.size() !== 2) begin n_err++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses.size()); end
        n_vec++; if (pulses.size() < 1 || pulses[0] !== 3) begin n_err++; $display("FAIL b2b_first_pulse_cycle: got %0d expected 3", pulses.size() > 0 ? pulses[0] : -1); end
        n_vec++; if (pulses.size() < 2 || pulses[1] !== 6) begin n_err++; $display("FAIL b2b_second_pulse_cycle: got %0d expected 6", pulses.size() > 1 ? pulses[1] : -1); end
        n_vec++; if (clicks.size() !== 1 || clicks[0] !== 3) begin n_err++; $display("FAIL b2b_click: got %0d clicks first at %0d expected 1 at 3", clicks.size(), clicks.size() > 0 ? clicks[0] : -1); end
        n_vec++; if (x1 !== 10'd321 || y1 !== 10'd239) begin n_err++; $display("FAIL b2b_first_pos: got (%0d,%0d) expected (321,239)", x1, y1); end
        n_vec++; if (cur_x !== 10'd323 || cur_y !== 10'd237) begin n_err++; $display("FAIL b2b_final_pos: got (%0d,%0d) expected (323,237)", cur_x, cur_y); end
        n_vec++; if (btn !== 3'b001) begin n_err++; $display("FAIL b2b_btn: got %b expected 001", btn); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        send_packet(0, 0, 3'b000, lat, ox, oy, ob, oc);
        n_vec++; if (oc !== 1'b0 || ob !== 3'b000) begin n_err++; $display("FAIL release_click: got click %b btn %b expected 0 000", oc, ob); end
        send_packet(0, 0, 3'b011, lat, ox, oy, ob, oc);
        n_vec++; if (oc !== 1'b1 || ob !== 3'b011) begin n_err++; $display("FAIL press_click: got click %b btn %b expected 1 011", oc, ob); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        do_reset();
        xm = 9'd10; ym = 9'd10; btnm = 3'b001; m_done_tick = 1'b1;
        @(posedge CLK);
        #1;
        idle_inputs();
        #2 RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (pos_tick) seen++;
        end
        @(posedge CLK);
        #1;
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midflight_no_pulse: got %0d pulses expected 0", seen); end
        n_vec++; if (cur_x !== 10'(X_INIT) || cur_y !== 10'(Y_INIT)) begin n_err++; $display("FAIL midflight_pos: got (%0d,%0d) expected (%0d,%0d)", cur_x, cur_y, X_INIT, Y_INIT); end
        n_vec++; if (btn !== 3'b000) begin n_err++; $display("FAIL midflight_btn: got %b expected 000", btn); end
    endtask

`ifdef CURSOR_FRAME_SYNC_EN
    task automatic test_frame_sync();
        int early = 0;
        do_reset();
        frame_start = 1'b0;
        xm = 9'd7; ym = 9'd0; btnm = 3'b000; m_done_tick = 1'b1;
        @(posedge CLK);
        #1;
        m_done_tick = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if (pos_tick || cur_x !== 10'(X_INIT)) early++;
            @(posedge CLK);
            #1;
        end
        frame_start = 1'b1;
        @(negedge CLK);
        n_vec++; if (early !== 0 || pos_tick !== 1'b0) begin n_err++; $display("FAIL sync_early_commit: got %0d early cycles, pos_tick %b expected 0 0", early, pos_tick); end
        @(posedge CLK);
        #1;
        frame_start = 1'b0;
        @(negedge CLK);
        n_vec++; if (pos_tick !== 1'b1) begin n_err++; $display("FAIL sync_pulse_after_frame: got %b expected 1", pos_tick); end
        n_vec++; if (cur_x !== 10'd327) begin n_err++; $display("FAIL sync_x: got %0d expected 327", cur_x); end
        @(posedge CLK);
        #1;
        frame_start = 1'b1;
        early = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (pos_tick) early++;
            @(posedge CLK);
            #1;
            frame_start = 1'b0;
        end
        n_vec++; if (early !== 0) begin n_err++; $display("FAIL sync_spurious_frame: got %0d pulses expected 0", early); end
        idle_inputs();
    endtask

    task automatic test_frame_reset();
        int seen = 0;
        do_reset();
        frame_start = 1'b0;
        xm = 9'd9; ym = 9'd9; btnm = 3'b001; m_done_tick = 1'b1;
        @(posedge CLK);
        #1;
        m_done_tick = 1'b0;
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        frame_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (pos_tick) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL sync_reset_pulse: got %0d expected 0", seen); end
        n_vec++; if (cur_x !== 10'(X_INIT) || cur_y !== 10'(Y_INIT)) begin n_err++; $display("FAIL sync_reset_pos: got (%0d,%0d) expected (%0d,%0d)", cur_x, cur_y, X_INIT, Y_INIT); end
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask
`endif

    // Reference: a packet occupies the engine for 3 cycles and commits at
    // start+3; one packet may wait; anything beyond that is dropped.
    task automatic test_random();
        localparam int N = 1500;
        exp_t q[$];
        int free_at = 0;
        bit pend_v = 0;
        int pdx = 0, pdy = 0;
        logic [2:0] pb = '0;
        int mx = X_INIT, my = Y_INIT;
        logic m_b0 = 1'b0;
        int vx = X_INIT, vy = Y_INIT;
        logic [2:0] vb = '0;
        logic m_ovr = 1'b0;
        do_reset();
        for (int c = 0; c < N; c++) begin
            bit tick;
            bit hit;
            logic exp_click;
            bit do_start;
            int sdx, sdy;
            logic [2:0] sb;
            tick = ($urandom_range(0, 99) < 40) && (c < N - 10);
            m_done_tick = tick;
            xm = 9'($urandom);
            ym = 9'($urandom);
            btnm = 3'($urandom);
            frame_start = SYNC_BUILD ? 1'b1 : 1'($urandom);
            @(negedge CLK);
            hit = (q.size() > 0) && (q[0].cyc == c);
            exp_click = 1'b0;
            if (hit) begin
                vx = q[0].x; vy = q[0].y; vb = q[0].b; exp_click = q[0].click;
                void'(q.pop_front());
            end
            n_vec++; if (pos_tick !== hit) begin n_err++; $display("FAIL rand_pos_tick cyc %0d: got %b expected %b", c, pos_tick, hit); end
            n_vec++; if (click_tick !== exp_click) begin n_err++; $display("FAIL rand_click cyc %0d: got %b expected %b", c, click_tick, exp_click); end
            n_vec++; if (cur_x !== 10'(vx)) begin n_err++; $display("FAIL rand_cur_x cyc %0d: got %0d expected %0d", c, cur_x, vx); end
            n_vec++; if (cur_y !== 10'(vy)) begin n_err++; $display("FAIL rand_cur_y cyc %0d: got %0d expected %0d", c, cur_y, vy); end
            n_vec++; if (btn !== vb) begin n_err++; $display("FAIL rand_btn cyc %0d: got %b expected %b", c, btn, vb); end
            n_vec++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rand_overrun cyc %0d: got %b expected %b", c, overrun, m_ovr); end
            do_start = 0; sdx = 0; sdy = 0; sb = '0;
            if (pend_v && c >= free_at) begin
                do_start = 1; sdx = pdx; sdy = pdy; sb = pb; pend_v = 0;
            end
            if (tick) begin
                if (!do_start && c >= free_at) begin
                    do_start = 1; sdx = int'($signed(xm)); sdy = int'($signed(ym)); sb = btnm;
                end else if (!pend_v) begin
                    pend_v = 1; pdx = int'($signed(xm)); pdy = int'($signed(ym)); pb = btnm;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (do_start) begin
                mx = clampi(mx + sdx, X_MAX);
                my = clampi(my - sdy, Y_MAX);
                q.push_back('{cyc: c + 3, x: mx, y: my, b: sb, click: sb[0] & ~m_b0});
                m_b0 = sb[0];
                free_at = c + 3;
            end
            @(posedge CLK);
            #1;
        end
        idle_inputs();
        n_vec++; if (q.size() !== 0 || pend_v) begin n_err++; $display("FAIL rand_drain: got %0d commits outstanding expected 0", q.size()); end
    endtask

    initial begin
        idle_inputs();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        test_reset();
        test_basic();
        test_clamp_high();
        test_clamp_low();
        test_back_to_back();
        test_reset_midflight();
`ifdef CURSOR_FRAME_SYNC_EN
        test_frame_sync();
        test_frame_reset();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mouse_cursor_tracker.md
MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

Interface
REQ-001 SHALL have parameter X_MAX, default 639, rightmost legal cursor column.
REQ-002 SHALL have parameter Y_MAX, default 479, bottom legal cursor row.
REQ-003 SHALL have parameter X_INIT, default 320, cursor column after reset.
REQ-004 SHALL have parameter Y_INIT, default 240, cursor row after reset.
REQ-005 CLK  input  1  sole clock; all state rising-edge.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 xm  input  9  two's-complement X delta from mouse packet.
REQ-008 ym  input  9  two's-complement Y delta; positive means up.
REQ-009 btnm  input  3  button levels {middle, right, left}.
REQ-010 m_done_tick  input  1  one-cycle pulse; xm/ym/btnm valid this cycle.
REQ-011 frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-012 cur_x  output  10  committed cursor column.
REQ-013 cur_y  output  10  committed cursor row.
REQ-014 btn  output  3  committed button levels.
REQ-015 pos_tick  output  1  one-cycle pulse when cur_x/cur_y/btn update.
REQ-016 click_tick  output  1  one-cycle pulse on left-button rising edge.
REQ-017 overrun  output  1  sticky; packet was dropped.

Function
REQ-018 SHALL run FSM states IDLE, SUM, CLAMP, COMMIT.
REQ-019 In IDLE, on m_done_tick, SHALL capture xm, ym, btnm and go to SUM.
REQ-020 SUM SHALL form 12-bit signed nx = cur_x + sext(xm) and ny = cur_y - sext(ym); screen Y grows downward.
REQ-021 CLAMP SHALL saturate: value < 0 -> 0; nx > X_MAX -> X_MAX; ny > Y_MAX -> Y_MAX; otherwise unchanged.
REQ-022 COMMIT SHALL load cur_x, cur_y and btn, pulse pos_tick for one cycle, and return to IDLE.
REQ-023 Without frame gating, latency from m_done_tick to pos_tick SHALL be exactly 3 cycles.
REQ-024 click_tick SHALL pulse in the COMMIT cycle when the new btn[0] is 1 and the previous btn[0] was 0.
REQ-025 An m_done_tick outside IDLE SHALL be held in a one-deep pending register.
REQ-026 A pending packet SHALL be consumed on the next entry to IDLE, with no idle cycle between.
REQ-027 An m_done_tick arriving while pending is full SHALL be dropped and SHALL set overrun.
REQ-028 overrun SHALL clear only on reset.
REQ-029 m_done_tick coincident with the COMMIT cycle SHALL go to pending and SHALL NOT be dropped.

Reset
REQ-030 While RST=0: cur_x=X_INIT, cur_y=Y_INIT, btn=0, pos_tick=0, click_tick=0, overrun=0, pending empty, FSM in IDLE.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight packet; no pos_tick SHALL follow.

Configuration
REQ-032 With CURSOR_FRAME_SYNC_EN defined, the FSM SHALL wait in COMMIT until frame_start, then update and pulse.
REQ-033 With CURSOR_FRAME_SYNC_EN defined, frame_start in the CLAMP-exit cycle SHALL count as the awaited pulse.
REQ-034 With CURSOR_FRAME_SYNC_EN defined, a frame_start with no clamped packet waiting SHALL be ignored.
REQ-035 Without CURSOR_FRAME_SYNC_EN, frame_start SHALL be ignored and COMMIT SHALL last one cycle.

Structure
REQ-036 Shared package SHALL hold the FSM state encoding, the delta width (9), the coordinate width (10) and the default extents 639/479.
REQ-037 A sub-module cursor_clamp (combinational signed saturate, one axis) SHALL be instantiated twice.

Verification
REQ-038 Reset, then xm=+5, ym=+3 tick -> pos_tick 3 cycles later; cur_x=325, cur_y=237.
REQ-039 Cursor at (630,5), xm=+20, ym=+10 -> cur_x=639, cur_y=0.
REQ-040 Cursor at (2,470), xm=-256, ym=-100 -> cur_x=0, cur_y=479.
REQ-041 Ticks on cycles 0, 1, 2 -> first two committed back-to-back; third dropped; overrun=1; click_tick only on a btn[0] 0->1 transition.
REQ-042 With CURSOR_FRAME_SYNC_EN, packet then frame_start 50 cycles later -> pos_tick in the cycle after frame_start.
REQ-043 With CURSOR_FRAME_SYNC_EN, RST low while waiting for frame_start -> outputs return to (320,240) with no pos_tick.
